// File: rtl/ir_nec_pkg.sv
// NEC IR timing constants (50 MHz clock cycles), transmitter state enum and
// small helpers shared by the transmitter and the receiver.
package ir_nec_pkg;

  localparam int unsigned NEC_LEAD_MARK_CYC  = 450000;   // 9 ms
  localparam int unsigned NEC_LEAD_SPACE_CYC = 225000;   // 4.5 ms
  localparam int unsigned NEC_BIT_MARK_CYC   = 28125;    // 562.5 us
  localparam int unsigned NEC_ZERO_SPACE_CYC = 28125;    // 562.5 us
  localparam int unsigned NEC_ONE_SPACE_CYC  = 84375;    // 1.6875 ms
  localparam int unsigned NEC_GAP_CYC        = 1000000;  // 20 ms
  localparam int unsigned NEC_CARRIER_DIV    = 1316;     // ~38 kHz

  // Receiver decision point between a 0-space and a 1-space.
  localparam int unsigned NEC_BIT_THRESH_CYC =
    (NEC_ZERO_SPACE_CYC + NEC_ONE_SPACE_CYC) / 2;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5,
    S_GAP        = 3'd6
  } tx_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // States in which the LED envelope is on.
  function automatic logic is_mark(input tx_state_e s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_transmit_nec_if.sv
// Request handshake of the NEC transmitter.
// start/busy: while busy is low the transmitter is idle and a cycle with
// start=1 is accepted, latching data_in that same cycle; busy is high from
// the next cycle until the frame and its gap are over. start while busy is
// ignored and not queued. done pulses for one cycle as busy falls, and start
// in that done cycle is accepted.
interface ir_transmit_nec_if;
  logic        start;
  logic [31:0] data_in;
  logic        busy;
  logic        done;

  modport master (output start, output data_in, input busy, input done);
  modport slave  (input start, input data_in, output busy, output done);
endinterface

// File: rtl/ir_carrier_gen.sv
// Carrier counter for the IR LED. The carrier output is the level the
// carrier will have in the next cycle, so the top level can register ir_out
// without an extra cycle of lag. restart forces the next cycle to phase 0
// (carrier high).
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int unsigned CARRIER_DIV = NEC_CARRIER_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic carrier
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CARRIER_DIV / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Next carrier phase: wrap at CARRIER_DIV-1, jump to 0 on restart.
  always_comb begin
    cnt_nxt = '0;
    if (!restart && (cnt != LAST)) cnt_nxt = cnt + CW'(1);
    carrier = (cnt_nxt < HALF);
  end

  // Carrier phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ir_transmit_nec.sv
// NEC IR transmitter: serialises a 32-bit word LSB-first as lead mark, lead
// space, 32 pulse-distance bits, stop mark and an idle gap. ir_out drives the
// LED (optionally carrier-modulated); ir_env/ir_env_n are raw envelopes.
module ir_transmit_nec
  import ir_nec_pkg::*;
#(
  parameter int unsigned LEAD_MARK_CYC  = NEC_LEAD_MARK_CYC,
  parameter int unsigned LEAD_SPACE_CYC = NEC_LEAD_SPACE_CYC,
  parameter int unsigned BIT_MARK_CYC   = NEC_BIT_MARK_CYC,
  parameter int unsigned ZERO_SPACE_CYC = NEC_ZERO_SPACE_CYC,
  parameter int unsigned ONE_SPACE_CYC  = NEC_ONE_SPACE_CYC,
  parameter int unsigned GAP_CYC        = NEC_GAP_CYC,
  parameter int unsigned CARRIER_DIV    = NEC_CARRIER_DIV,
  parameter bit          CARRIER_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  ir_transmit_nec_if.slave  bus,
  output logic              ir_out,
  output logic              ir_env,
  output logic              ir_env_n,
  output tx_state_e         dbg_state
);

  localparam int unsigned MAX_DUR =
    max_u(max_u(max_u(LEAD_MARK_CYC, LEAD_SPACE_CYC), max_u(BIT_MARK_CYC, ZERO_SPACE_CYC)),
          max_u(ONE_SPACE_CYC, GAP_CYC));
  localparam int DW = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  tx_state_e     state;
  tx_state_e     state_nxt;
  logic [DW-1:0] dur_cnt;
  logic [DW-1:0] dur_last;   // length of the current phase minus one
  logic          phase_done;
  logic [31:0]   shift;
  logic [4:0]    bit_idx;
  logic          env_nxt;
  logic          restart;
  logic          carrier;

  assign dbg_state = state;

  ir_carrier_gen #(.CARRIER_DIV(CARRIER_DIV)) u_carrier (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .carrier (carrier)
  );

  // Last count value of the current phase; the space length follows the bit in shift[0].
  always_comb begin
    dur_last = '0;
    unique case (state)
      S_LEAD_MARK:  dur_last = DW'(LEAD_MARK_CYC - 1);
      S_LEAD_SPACE: dur_last = DW'(LEAD_SPACE_CYC - 1);
      S_BIT_MARK:   dur_last = DW'(BIT_MARK_CYC - 1);
      S_BIT_SPACE:  dur_last = shift[0] ? DW'(ONE_SPACE_CYC - 1) : DW'(ZERO_SPACE_CYC - 1);
      S_STOP_MARK:  dur_last = DW'(BIT_MARK_CYC - 1);
      S_GAP:        dur_last = DW'(GAP_CYC - 1);
      default:      dur_last = '0;
    endcase
    phase_done = (state != S_IDLE) && (dur_cnt == dur_last);
  end

  // Next-state logic; mark entry restarts the carrier so every mark starts high.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (bus.start)  state_nxt = S_LEAD_MARK;
      S_LEAD_MARK:  if (phase_done) state_nxt = S_LEAD_SPACE;
      S_LEAD_SPACE: if (phase_done) state_nxt = S_BIT_MARK;
      S_BIT_MARK:   if (phase_done) state_nxt = S_BIT_SPACE;
      S_BIT_SPACE:  if (phase_done) state_nxt = (bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (phase_done) state_nxt = S_GAP;
      S_GAP:        if (phase_done) state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
    env_nxt = is_mark(state_nxt);
    restart = env_nxt && (state_nxt != state);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Phase counter, data shift register and bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_cnt <= '0;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      if ((state == S_IDLE) || phase_done) dur_cnt <= '0;
      else                                 dur_cnt <= dur_cnt + DW'(1);
      if ((state == S_IDLE) && bus.start) begin
        shift   <= bus.data_in;
        bit_idx <= '0;
      end else if ((state == S_BIT_SPACE) && phase_done) begin
        shift   <= {1'b0, shift[31:1]};
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end

  // Registered outputs, computed from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      ir_env   <= 1'b0;
      ir_env_n <= 1'b1;
      ir_out   <= 1'b0;
    end else begin
      bus.busy <= (state_nxt != S_IDLE);
      bus.done <= (state == S_GAP) && phase_done;
      ir_env   <= env_nxt;
      ir_env_n <= ~env_nxt;
      ir_out   <= env_nxt & (carrier | ~CARRIER_EN);
    end
  end

endmodule

// File: tb/tb_ir_transmit_nec.sv
// Bench for ir_transmit_nec with shortened phase lengths. A reference model
// describes each frame as 68 alternating envelope segments computed from the
// word; the observed envelope is run-length captured and compared.
module tb_ir_transmit_nec;
  import ir_nec_pkg::*;

  localparam int LM   = 40;
  localparam int LS   = 20;
  localparam int BM   = 6;
  localparam int ZS   = 4;
  localparam int OS   = 12;
  localparam int GAP  = 30;
  localparam int CDIV = 5;
  localparam int BUDGET = 3000;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      ir_out;
  logic      ir_env;
  logic      ir_env_n;
  tx_state_e dbg_state;

  ir_transmit_nec_if bus ();

  ir_transmit_nec #(
    .LEAD_MARK_CYC  (LM),
    .LEAD_SPACE_CYC (LS),
    .BIT_MARK_CYC   (BM),
    .ZERO_SPACE_CYC (ZS),
    .ONE_SPACE_CYC  (OS),
    .GAP_CYC        (GAP),
    .CARRIER_DIV    (CDIV),
    .CARRIER_EN     (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ir_out    (ir_out),
    .ir_env    (ir_env),
    .ir_env_n  (ir_env_n),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          frames_expected = 0;
  int          done_pulses = 0;

  int          cap_len[$];
  logic        cap_lvl[$];
  int          cap_cycles;
  int          out_err;
  int          envn_err;
  int          done_err;
  bit          capturing = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int seg_len(input logic [31:0] w, input int k);
    if (k == 0) return LM;
    if (k == 1) return LS;
    if (k == 66) return BM;
    if (k == 67) return GAP;
    if (k % 2 == 0) return BM;
    return w[5'((k - 3) / 2)] ? OS : ZS;
  endfunction

  function automatic logic seg_lvl(input int k);
    if (k == 66) return 1'b1;
    return (k < 66) && (k % 2 == 0);
  endfunction

  function automatic logic [31:0] decode_spaces();
    logic [31:0] d;
    d = '0;
    for (int j = 0; j < 32; j++)
      if (3 + 2 * j < cap_len.size()) d[5'(j)] = (cap_len[3 + 2 * j] > (ZS + OS) / 2);
    return d;
  endfunction

  task automatic check_frame();
    logic [31:0] w;
    int ones;
    int bad;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'd1, 32'd0);
      return;
    end
    w = exp_q.pop_front();
    ones = $countones(w);
    check("frame_len", cap_cycles, LM + LS + 33 * BM + ones * OS + (32 - ones) * ZS + GAP);
    check("seg_count", cap_len.size(), 68);
    bad = 0;
    for (int k = 0; k < cap_len.size() && k < 68; k++)
      if ((cap_len[k] != seg_len(w, k)) || (cap_lvl[k] !== seg_lvl(k))) bad++;
    check("segments_bad", bad, 0);
    check("decoded_word", decode_spaces(), w);
    check("ir_out_carrier_err", out_err, 0);
    check("ir_env_n_err", envn_err, 0);
    check("done_while_busy", done_err, 0);
  endtask

  // Per-cycle monitor, called once after each falling edge.
  task automatic sample();
    int   last;
    logic exp_out;
    if (!rst_n) begin
      capturing = 1'b0;
      return;
    end
    if (bus.done) done_pulses++;
    if (bus.busy) begin
      if (!capturing) begin
        capturing = 1'b1;
        cap_len.delete();
        cap_lvl.delete();
        cap_cycles = 0;
        out_err = 0;
        envn_err = 0;
        done_err = 0;
      end
      cap_cycles++;
      if (cap_lvl.size() == 0) begin
        cap_lvl.push_back(ir_env);
        cap_len.push_back(1);
      end else if (cap_lvl[cap_lvl.size() - 1] !== ir_env) begin
        cap_lvl.push_back(ir_env);
        cap_len.push_back(1);
      end else begin
        cap_len[cap_len.size() - 1] = cap_len[cap_len.size() - 1] + 1;
      end
      last = cap_len.size() - 1;
      exp_out = ir_env ? (((cap_len[last] - 1) % CDIV) < CDIV / 2) : 1'b0;
      if (ir_out !== exp_out) out_err++;
      if (ir_env_n !== ~ir_env) envn_err++;
      if (bus.done) done_err++;
    end else if (capturing) begin
      capturing = 1'b0;
      check("done_at_busy_fall", 32'(bus.done), 32'd1);
      check_frame();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    while (bus.busy && n < BUDGET) begin
      tick();
      n++;
    end
    if (bus.busy) check("send_wait_idle_timeout", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    bus.data_in = w;
    exp_q.push_back(w);
    frames_expected++;
    tick();
    bus.start = 1'b0;
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_env", 32'(ir_env), 32'd1);
    check("accept_state", 32'(dbg_state), 32'(S_LEAD_MARK));
  endtask

  // Wait for the frame in flight to end; optionally disturb start/data_in
  // while busy, and optionally chain a new request in the done cycle.
  task automatic run_frame(input bit noise, input bit chain, input logic [31:0] next_w);
    int n;
    n = 0;
    while (bus.busy && n < BUDGET) begin
      tick();
      n++;
      if (bus.busy && noise) begin
        bus.data_in = $urandom;
        bus.start = ($urandom_range(0, 7) == 0);
      end else begin
        bus.start = 1'b0;
      end
    end
    if (bus.busy) check("frame_timeout", 32'(bus.busy), 32'd0);
    if (chain) begin
      check("chain_in_done_cycle", 32'(bus.done), 32'd1);
      bus.start = 1'b1;
      bus.data_in = next_w;
      exp_q.push_back(next_w);
      frames_expected++;
      tick();
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_env", 32'(ir_env), 32'd1);
      check("b2b_state", 32'(dbg_state), 32'(S_LEAD_MARK));
    end
  endtask

  task automatic reset_test();
    int        entries;
    int        n;
    tx_state_e prev;
    send(32'h5A5A_1234 ^ $urandom);
    entries = 0;
    n = 0;
    prev = dbg_state;
    while (entries < 13 && n < BUDGET) begin
      tick();
      n++;
      if ((dbg_state == S_BIT_SPACE) && (prev != S_BIT_SPACE)) entries++;
      prev = dbg_state;
    end
    check("reach_bit12_space", entries, 13);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_ir_out", 32'(ir_out), 32'd0);
    check("arst_ir_env", 32'(ir_env), 32'd0);
    check("arst_ir_env_n", 32'(ir_env_n), 32'd1);
    check("arst_state", 32'(dbg_state), 32'(S_IDLE));
    exp_q.delete();
    frames_expected--;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 1'b0;
    bus.data_in = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ir_out", 32'(ir_out), 32'd0);
    check("rst_ir_env", 32'(ir_env), 32'd0);
    check("rst_ir_env_n", 32'(ir_env_n), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    repeat (2) tick();

    send(32'h0000_0000);
    run_frame(1'b0, 1'b0, 32'h0);

    send(32'hB54A_02FD);
    run_frame(1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    check("start_not_queued", 32'(bus.busy), 32'd0);

    send($urandom);
    run_frame(1'b0, 1'b1, 32'hFFFF_FFFF);
    run_frame(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 5; i++) begin
      send($urandom);
      run_frame(i % 2 == 1, 1'b0, 32'h0);
    end

    reset_test();
    send($urandom);
    run_frame(1'b0, 1'b0, 32'h0);

    repeat (3) tick();
    check("done_pulse_count", done_pulses, frames_expected);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_transmit_nec.md
# ir_transmit_nec

NEC-protocol infrared transmitter, the transmit counterpart of the team's NEC IR receiver on the DE10 board (50 MHz `clk`). It accepts a 32-bit word on a start/busy handshake and serialises it LSB-first as an NEC frame: lead mark, lead space, 32 pulse-distance bits, stop mark, then a guaranteed idle gap. The output is `ir_out`, which can be carrier-modulated to drive an IR LED. It also provides `ir_env` and `ir_env_n`, unmodulated envelopes for board-level or simulation loopback into the receiver.

## Interface
- `LEAD_MARK_CYC`, 450000, lead mark length (9 ms).
- `LEAD_SPACE_CYC`, 225000, lead space length (4.5 ms).
- `BIT_MARK_CYC`, 28125, mark length for every data bit and for the stop mark (562.5 us).
- `ZERO_SPACE_CYC`, 28125, space length after the mark of a logical 0 (562.5 us).
- `ONE_SPACE_CYC`, 84375, space length after the mark of a logical 1 (1.6875 ms).
- `GAP_CYC`, 1000000, idle space after the stop mark before `busy` falls (20 ms).
- `CARRIER_DIV`, 1316, carrier period in clk cycles (≈38 kHz).
- `CARRIER_EN`, 1, selects the `ir_out` mode: 1 = modulate marks with the carrier, 0 = output the raw envelope.
- `clk`  in  1  50 MHz clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request to send; sampled only in IDLE.
- `data_in`  in  32  word to send; bit 0 is sent first; latched when `start` is accepted.
- `busy`  out  1  high from the cycle after acceptance until the cycle after the gap ends.
- `done`  out  1  one-cycle pulse when a frame, including its gap, completes.
- `ir_out`  out  1  LED drive, 1 = emitting.
- `ir_env`  out  1  envelope, 1 = mark.
- `ir_env_n`  out  1  inverted envelope, matching the receiver-module polarity (low during mark).

## Operation
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
- IDLE with `start`=1:
  - latch `data_in` into a shift register;
  - clear `bit_idx` (5 bits);
  - enter LEAD_MARK.
- `start` while `busy` is ignored. It is not queued.
- Phase counter `dur_cnt`, width `$clog2` of the largest duration parameter (20 bits at defaults):
  - cleared on entry to each state;
  - the state exits when `dur_cnt == DUR-1`, so each phase lasts exactly DUR cycles.
- Transitions:
  - LEAD_MARK → LEAD_SPACE → BIT_MARK.
  - BIT_MARK → BIT_SPACE. The space length is `ONE_SPACE_CYC` when `shift[0]`=1, otherwise `ZERO_SPACE_CYC`.
  - At the end of BIT_SPACE: shift right and increment `bit_idx`. If `bit_idx` was 31, go to STOP_MARK; otherwise go to BIT_MARK.
  - STOP_MARK → GAP → IDLE.
- `ir_env`=1 in LEAD_MARK, BIT_MARK and STOP_MARK; 0 in all other states. `ir_env_n` = ~`ir_env`.
- Carrier:
  - counter 0..`CARRIER_DIV`-1; carrier is high while count < `CARRIER_DIV`/2;
  - the counter resets to 0 on entry to every mark, so each mark begins with the carrier high.
- `ir_out` = `ir_env` & carrier when `CARRIER_EN`=1; `ir_out` = `ir_env` when `CARRIER_EN`=0.
- The word is transmitted verbatim, with no complement insertion. Callers build {~cmd, cmd, ~addr, addr}.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `ir_out`=0, `ir_env`=0, `ir_env_n`=1, state IDLE.
- `start` sampled high in cycle N: `busy`=1 and `ir_env`=1 from cycle N+1.
- Frame length from the `busy` rise to the `busy` fall:
  - LEAD_MARK_CYC + LEAD_SPACE_CYC + 32·BIT_MARK_CYC + (ones·ONE_SPACE_CYC + zeros·ZERO_SPACE_CYC) + BIT_MARK_CYC + GAP_CYC;
  - at defaults with all-zero data this is 3,503,125 cycles.
- Completion: `done`=1 and `busy`=0 in the same cycle, which is the cycle after the last GAP cycle. The state is IDLE in that cycle.
- Back-to-back frames: `start` high in the `done` cycle is accepted, and the next lead mark begins the following cycle.
- Reset asserted mid-frame: immediate return to IDLE with LED off and no `done` pulse. The latched data is discarded.
- `data_in` changes while `busy` have no effect on the frame in flight.

## Structure
- Package `ir_nec_pkg` holds the NEC timing constants (durations in 50 MHz cycles) and the state enum. The receiver thresholds are re-derived from the same package.
- Sub-module `ir_carrier_gen` holds the carrier counter, with `restart`, `clk` and `rst_n` inputs and a `carrier` output. The FSM, phase counter and shift register stay in the top level.

## Test plan
All scenarios use scaled parameters (÷100) for simulation speed; the waveform checks are repeated once at defaults.
- Send `data_in` 0x00000000 at defaults → `busy` high for exactly 3,503,125 cycles. The 33 marks are each 28125 cycles long; `done` pulses once.
- Send 0xB54A02FD in loopback: `ir_env_n` feeds the receiver data input → the receiver asserts data ready and outputs 0xB54A02FD. The measured space pattern decodes LSB-first to 0xB54A02FD (bit 0 is a 1-space of 84375 cycles).
- Pulse `start` again at mid-frame → it is ignored. Exactly one frame is sent; `data_in` changes during the frame do not alter the transmitted bits.
- Raise `start` in the `done` cycle with 0xFFFFFFFF → the lead mark starts the next cycle. The frame length equals the formula with 32 ones.
- Assert reset during BIT_SPACE of bit 12 → `ir_out`=0 and `busy`=0 asynchronously, with no `done` pulse. A new `start` then sends a full frame.
- With `CARRIER_EN`=1, check `ir_out` during the lead mark → a 1316-cycle period with 658 high cycles, starting high. `ir_out`=0 throughout the spaces.
